csr_gpio_bank: RTL and testbench
================================

Name: csr_gpio_bank

Overview:
Parametrised CSR-mapped GPIO bank that replaces the fixed two-in/two-out I/O decode inside the core's execute/writeback path.
- Provides N_IN synchronised input channels, each with change detection.
- Provides N_OUT output registers with readback.
- Provides a sticky change-status register with a maskable interrupt.
- Sits beside the register file. The core drives CSR address, strobes and write data from EX; read data is returned registered, ready for the WB writedata mux.

Parameters:
WIDTH, 32, data width of every channel and CSR.
N_IN, 2, number of input channels (1..WIDTH).
N_OUT, 2, number of output channels (1..16).
IN_BASE, 12'hF00, CSR address of input channel 0; channel i is at IN_BASE+i.
OUT_BASE, 12'hF02, CSR address of output channel 0; channel j is at OUT_BASE+j.
STAT_ADDR, 12'hF10, change-status CSR.
MASK_ADDR, 12'hF11, interrupt-mask CSR.
SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
csr_addr  in  12  CSR address, valid with csr_re/csr_we.
csr_re  in  1  read strobe.
csr_we  in  1  write strobe.
csr_wdata  in  WIDTH  write data.
csr_rdata  out  WIDTH  registered read data.
csr_hit  out  1  registered: previous-cycle read hit a mapped address.
gpio_in  in  N_IN*WIDTH  asynchronous inputs, channel i at [i*WIDTH +: WIDTH].
gpio_out  out  N_OUT*WIDTH  output registers, same packing.
change_irq  out  1  |(stat & mask), registered.

Behaviour:
- Reset (rst=1 at a clk edge) clears all state: gpio_out=0, csr_rdata=0, csr_hit=0, change_irq=0, stat=0, mask=0, synchroniser flops=0, prev-sample regs=0, arm counter=0.
- Synchroniser: each input channel passes through SYNC_STAGES flops. sync_i is the last stage.
- Change detection: prev_i <= sync_i every cycle. Compare is full-width. Detect_i = (sync_i != prev_i) && armed.
- Arm counter:
  - Counts 0..SYNC_STAGES after reset, saturating.
  - armed=1 only when the count equals SYNC_STAGES.
  - Suppresses spurious flags while the synchroniser flushes.
- Stat register: bit i (i<N_IN) is sticky, set by detect_i. Bits >= N_IN read 0.
- Clearing stat:
  - A read of STAT_ADDR clears all bits that were set at the time of the read.
  - A write to STAT_ADDR clears the bits where wdata=1 (W1C).
  - A detect in the same cycle as either clear wins: the bit stays 1.
- Mask: plain R/W register, low N_IN bits. Upper bits read 0.
- change_irq <= |(stat_next & mask_next), i.e. it asserts the cycle after the flag/mask edge.
- Read: latency 1. csr_re sampled at edge k gives csr_rdata/csr_hit valid after edge k.
  - IN_BASE+i returns sync_i.
  - OUT_BASE+j returns gpio_out[j].
  - STAT_ADDR returns stat; MASK_ADDR returns mask.
  - Unmapped address returns 0 with csr_hit=0.
  - When csr_re=0, csr_rdata holds its value and csr_hit<=0.
- Write: csr_we at edge k updates the target register at edge k; the new gpio_out is visible after edge k.
  - Writes to input addresses or unmapped addresses are ignored.
- Simultaneous csr_re and csr_we to the same address: the read returns the pre-write value and the write applies.
- Address decode is an exact compare. Ranges must not overlap; an elaboration-time assertion fails on overlap, N_IN>WIDTH, N_OUT>16 or SYNC_STAGES<2.
- Reset asserted mid-operation overrides any strobe in that cycle.

Decomposition:
- Package gpio_pkg holds:
  - default address constants (IN_BASE/OUT_BASE/STAT/MASK);
  - a csr_req_t struct (addr, re, we, wdata);
  - the function in_range(addr, base, n).
- Sub-module gpio_sync_chain (WIDTH, SYNC_STAGES): one per input channel, synchronous active-high reset. Everything else lives inline in csr_gpio_bank.

Test Plan:
- Reset, then read 12'hF02 and 12'hF03 -> csr_rdata=0, csr_hit=1. Read 12'hF10 -> 0. change_irq=0, even with gpio_in toggling during the first SYNC_STAGES cycles.
- Write 32'hDEADBEEF to 12'hF03 -> gpio_out[63:32]=32'hDEADBEEF after the same edge. Read 12'hF03 the next cycle -> csr_rdata=32'hDEADBEEF one cycle later.
- gpio_in ch0 steps 0 -> 32'h5 after arming -> csr_rdata from 12'hF00 shows 5 no earlier than SYNC_STAGES edges later, and stat=32'h1. With mask=1, change_irq=1 one cycle after stat sets.
- Read 12'hF10 with stat=1 while ch1 changes in the same cycle -> csr_rdata=1, then stat=2 (bit0 cleared, bit1 set). A detect on bit0 coincident with a W1C write of 1 -> bit0 stays 1.
- Read 12'h123 -> csr_rdata=0, csr_hit=0. Write to 12'hF00 -> no state change.
- Same-cycle csr_re+csr_we to 12'hF02 with old value 7, new value 9 -> csr_rdata=7, gpio_out[31:0]=9. Then assert rst together with csr_we -> gpio_out=0 and the write is dropped.

Source files
------------

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pkg
// Brief    : Shared constants, CSR request record and address-range helper
//            for the CSR-mapped GPIO bank.
// Revision : 1.0  initial release
// ============================================================================
package gpio_pkg;

    localparam int          c_csr_aw      = 12;
    localparam int          c_req_dw      = 32;

    // Default CSR map
    localparam logic [11:0] c_in_base     = 12'hF00;
    localparam logic [11:0] c_out_base    = 12'hF02;
    localparam logic [11:0] c_stat_addr   = 12'hF10;
    localparam logic [11:0] c_mask_addr   = 12'hF11;

    typedef struct packed {
        logic [c_csr_aw-1:0] addr;
        logic                re;
        logic                we;
        logic [c_req_dw-1:0] wdata;
    } csr_req_t;

    // True when addr lies in [base, base+n); evaluated in int to avoid wrap.
    function automatic logic in_range(input logic [11:0] addr,
                                      input logic [11:0] base,
                                      input int          n);
        int a;
        int b;
        a = int'(addr);
        b = int'(base);
        return (a >= b) && (a < b + n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_gpio_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_gpio_bank_if
// Brief    : CSR access bus between the core (EX stage) and the GPIO bank.
// Revision : 1.0  initial release
// ============================================================================
interface csr_gpio_bank_if
    import gpio_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    logic [c_csr_aw-1:0] csr_addr;
    logic                csr_re;
    logic                csr_we;
    logic [WIDTH-1:0]    csr_wdata;
    logic [WIDTH-1:0]    csr_rdata;
    logic                csr_hit;

    modport master (
        output csr_addr, csr_re, csr_we, csr_wdata,
        input  csr_rdata, csr_hit
    );

    modport slave (
        input  csr_addr, csr_re, csr_we, csr_wdata,
        output csr_rdata, csr_hit
    );
endinterface
`default_nettype wire

// File: rtl/gpio_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sync_chain
// Brief    : Multi-flop synchroniser for one asynchronous input channel.
// Revision : 1.0  initial release
// ============================================================================
module gpio_sync_chain #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    // Shift the asynchronous sample through the flop chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= d;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign q = r_stage[SYNC_STAGES-1];
endmodule
`default_nettype wire

// File: rtl/csr_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : csr_gpio_bank
// Brief    : CSR-mapped GPIO bank: synchronised inputs with sticky change
//            flags and maskable interrupt, output registers with readback,
//            registered read data for the WB writedata mux.
// Revision : 1.0  initial release
// ============================================================================
module csr_gpio_bank
    import gpio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          N_IN        = 2,
    parameter int          N_OUT       = 2,
    parameter logic [11:0] IN_BASE     = c_in_base,
    parameter logic [11:0] OUT_BASE    = c_out_base,
    parameter logic [11:0] STAT_ADDR   = c_stat_addr,
    parameter logic [11:0] MASK_ADDR   = c_mask_addr,
    parameter int          SYNC_STAGES = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    csr_gpio_bank_if.slave              csr,
    input  wire logic [N_IN*WIDTH-1:0]  gpio_in,
    output logic      [N_OUT*WIDTH-1:0] gpio_out,
    output logic                        change_irq
);
    // ------------------------------------------------------------------
    // Configuration sanity: overlapping CSR ranges or illegal sizes
    // ------------------------------------------------------------------
    localparam int c_in_lo  = int'(IN_BASE);
    localparam int c_out_lo = int'(OUT_BASE);
    localparam bit c_ov_io  = (c_in_lo < c_out_lo + N_OUT) && (c_out_lo < c_in_lo + N_IN);
    localparam bit c_ov_sm  = in_range(STAT_ADDR, IN_BASE, N_IN)  ||
                              in_range(STAT_ADDR, OUT_BASE, N_OUT) ||
                              in_range(MASK_ADDR, IN_BASE, N_IN)  ||
                              in_range(MASK_ADDR, OUT_BASE, N_OUT) ||
                              (STAT_ADDR == MASK_ADDR);
    localparam bit c_bad_sz = (N_IN < 1) || (N_IN > WIDTH) || (N_OUT < 1) ||
                              (N_OUT > 16) || (SYNC_STAGES < 2);

    generate
        if (c_ov_io || c_ov_sm || c_bad_sz) begin : g_cfg_check
            $error("csr_gpio_bank: illegal configuration (overlap or size)");
        end
    endgenerate

    localparam int                 c_cnt_w    = $clog2(SYNC_STAGES + 1);
    localparam logic [c_cnt_w-1:0] c_arm_full = c_cnt_w'(SYNC_STAGES);

    logic [WIDTH-1:0]   w_sync [N_IN];
    logic [WIDTH-1:0]   r_prev [N_IN];
    logic [WIDTH-1:0]   r_out  [N_OUT];
    logic [c_cnt_w-1:0] r_arm_cnt;
    logic               w_armed;
    logic [N_IN-1:0]    w_detect;
    logic [N_IN-1:0]    r_stat;
    logic [N_IN-1:0]    r_mask;
    logic [N_IN-1:0]    w_stat_clr;
    logic [N_IN-1:0]    w_stat_next;
    logic [N_IN-1:0]    w_mask_next;
    logic               w_stat_sel;
    logic               w_mask_sel;
    logic [WIDTH-1:0]   w_rd_data;
    logic               w_rd_hit;

    // ------------------------------------------------------------------
    // Input synchronisers and output packing
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_in_ch
            gpio_sync_chain #(
                .WIDTH       (WIDTH),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (gpio_in[gi*WIDTH +: WIDTH]),
                .q   (w_sync[gi])
            );
        end
        for (genvar gj = 0; gj < N_OUT; gj++) begin : g_out_pack
            assign gpio_out[gj*WIDTH +: WIDTH] = r_out[gj];
        end
    endgenerate

    // Arm counter: hold off change detection until the synchroniser has flushed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arm_cnt <= '0;
        end else if (r_arm_cnt != c_arm_full) begin
            r_arm_cnt <= r_arm_cnt + c_cnt_w'(1);
        end
    end

    assign w_armed = (r_arm_cnt == c_arm_full);

    // Previous synchronised sample per channel for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                r_prev[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                r_prev[i] <= w_sync[i];
            end
        end
    end

    // Full-width change detect per channel
    always_comb begin
        w_detect = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_detect[i] = (w_sync[i] != r_prev[i]) && w_armed;
        end
    end

    // ------------------------------------------------------------------
    // Status / mask next-state; a coincident detect beats any clear
    // ------------------------------------------------------------------
    assign w_stat_sel = (csr.csr_addr == STAT_ADDR);
    assign w_mask_sel = (csr.csr_addr == MASK_ADDR);

    // Read-to-clear drops every bit visible to the read; W1C drops written ones
    always_comb begin
        w_stat_clr = '0;
        if (csr.csr_re && w_stat_sel) begin
            w_stat_clr = w_stat_clr | r_stat;
        end
        if (csr.csr_we && w_stat_sel) begin
            w_stat_clr = w_stat_clr | csr.csr_wdata[N_IN-1:0];
        end
    end

    assign w_stat_next = (r_stat & ~w_stat_clr) | w_detect;
    assign w_mask_next = (csr.csr_we && w_mask_sel) ? csr.csr_wdata[N_IN-1:0] : r_mask;

    // Sticky status, mask and the interrupt built from their next values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat     <= '0;
            r_mask     <= '0;
            change_irq <= 1'b0;
        end else begin
            r_stat     <= w_stat_next;
            r_mask     <= w_mask_next;
            change_irq <= |(w_stat_next & w_mask_next);
        end
    end

    // Output register writes; input and unmapped addresses are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_OUT; j++) begin
                r_out[j] <= '0;
            end
        end else if (csr.csr_we) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (csr.csr_addr == OUT_BASE + 12'(j)) begin
                    r_out[j] <= csr.csr_wdata;
                end
            end
        end
    end

    // Read mux over the current (pre-write) register values
    always_comb begin
        w_rd_data = '0;
        w_rd_hit  = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (csr.csr_addr == IN_BASE + 12'(i)) begin
                w_rd_data = w_sync[i];
                w_rd_hit  = 1'b1;
            end
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (csr.csr_addr == OUT_BASE + 12'(j)) begin
                w_rd_data = r_out[j];
                w_rd_hit  = 1'b1;
            end
        end
        if (w_stat_sel) begin
            w_rd_data = WIDTH'(r_stat);
            w_rd_hit  = 1'b1;
        end
        if (w_mask_sel) begin
            w_rd_data = WIDTH'(r_mask);
            w_rd_hit  = 1'b1;
        end
    end

    // Registered read return; data holds between reads, hit is a one-cycle flag
    always_ff @(posedge clk) begin
        if (rst) begin
            csr.csr_rdata <= '0;
            csr.csr_hit   <= 1'b0;
        end else if (csr.csr_re) begin
            csr.csr_rdata <= w_rd_data;
            csr.csr_hit   <= w_rd_hit;
        end else begin
            csr.csr_hit   <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_csr_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_gpio_bank
// Brief    : Table-driven self-checking bench for csr_gpio_bank with a
//            read-return scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_csr_gpio_bank;
    import gpio_pkg::*;

    localparam int WIDTH       = 32;
    localparam int N_IN        = 2;
    localparam int N_OUT       = 2;
    localparam int SYNC_STAGES = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_IN*WIDTH-1:0]  gpio_in;
    logic [N_OUT*WIDTH-1:0] gpio_out;
    logic                   change_irq;

    csr_gpio_bank_if #(.WIDTH(WIDTH)) bus ();

    csr_gpio_bank #(
        .WIDTH       (WIDTH),
        .N_IN        (N_IN),
        .N_OUT       (N_OUT),
        .IN_BASE     (12'hF00),
        .OUT_BASE    (12'hF02),
        .STAT_ADDR   (12'hF10),
        .MASK_ADDR   (12'hF11),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .csr        (bus),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .change_irq (change_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        csr_req_t    req;
        logic [63:0] gin;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic        chk_out;
        logic [63:0] exp_out;
        logic        chk_irq;
        logic        exp_irq;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        hit;
        int          idx;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(logic r, logic [11:0] a, logic re, logic we,
                                logic [31:0] wd, logic [63:0] g,
                                logic [31:0] er, logic eh,
                                logic co, logic [63:0] eo,
                                logic ci, logic ei);
        vec_t v;
        v.rst       = r;
        v.req.addr  = a;
        v.req.re    = re;
        v.req.we    = we;
        v.req.wdata = wd;
        v.gin       = g;
        v.exp_rdata = er;
        v.exp_hit   = eh;
        v.chk_out   = co;
        v.exp_out   = eo;
        v.chk_irq   = ci;
        v.exp_irq   = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one vector at a negedge, push its read expectation, compare after the edge
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        rst           = v.rst;
        bus.csr_addr  = v.req.addr;
        bus.csr_re    = v.req.re;
        bus.csr_we    = v.req.we;
        bus.csr_wdata = v.req.wdata;
        gpio_in       = v.gin;
        sb_q.push_back('{rdata: v.exp_rdata, hit: v.exp_hit, idx: idx});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check($sformatf("v%0d scoreboard empty", idx), 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("v%0d rdata", e.idx), {32'd0, bus.csr_rdata}, {32'd0, e.rdata});
            check($sformatf("v%0d hit", e.idx), {63'd0, bus.csr_hit}, {63'd0, e.hit});
        end
        if (v.chk_out) check($sformatf("v%0d gpio_out", idx), gpio_out, v.exp_out);
        if (v.chk_irq) check($sformatf("v%0d change_irq", idx), {63'd0, change_irq}, {63'd0, v.exp_irq});
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        localparam logic [63:0] G0  = 64'h0000_0000_0000_0000;
        localparam logic [63:0] G5  = 64'h0000_0000_0000_0005;
        localparam logic [63:0] G35 = 64'h0000_0003_0000_0005;
        localparam logic [63:0] G36 = 64'h0000_0003_0000_0006;
        localparam logic [63:0] G46 = 64'h0000_0004_0000_0006;
        localparam logic [63:0] G11 = 64'h0000_0001_0000_0001;
        localparam logic [63:0] G22 = 64'h0000_0002_0000_0002;
        localparam logic [63:0] O1  = 64'hDEADBEEF_00000000;
        localparam logic [63:0] O7  = 64'hDEADBEEF_00000007;
        localparam logic [63:0] O9  = 64'hDEADBEEF_00000009;

        //                 rst addr     re    we    wdata         gin  rdata         hit   chko  out   chki  irq
        tbl.push_back(mk(0, 12'hF02, 1'b1, 1'b0, 32'h0,        G0,  32'h0,        1'b1, 1'b1, 64'h0, 1'b1, 1'b0)); // 0
        tbl.push_back(mk(0, 12'hF03, 1'b1, 1'b0, 32'h0,        G0,  32'h0,        1'b1, 1'b0, 64'h0, 1'b0, 1'b0)); // 1
        tbl.push_back(mk(0, 12'hF10, 1'b1, 1'b0, 32'h0,        G0,  32'h0,        1'b1, 1'b0, 64'h0, 1'b1, 1'b0)); // 2
        tbl.push_back(mk(0, 12'hF03, 1'b0, 1'b1, 32'hDEADBEEF, G0,  32'h0,        1'b0, 1'b1, O1,    1'b0, 1'b0)); // 3
        tbl.push_back(mk(0, 12'hF03, 1'b1, 1'b0, 32'h0,        G0,  32'hDEADBEEF, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0)); // 4
        tbl.push_back(mk(0, 12'h123, 1'b1, 1'b0, 32'h0,        G0,  32'h0,        1'b0, 1'b0, 64'h0, 1'b0, 1'b0)); // 5
        tbl.push_back(mk(0, 12'hF00, 1'b0, 1'b1, 32'hFFFFFFFF, G0,  32'h0,        1'b0, 1'b1, O1,    1'b0, 1'b0)); // 6
        tbl.push_back(mk(0, 12'hF00, 1'b1, 1'b0, 32'h0,        G0,  32'h0,        1'b1, 1'b0, 64'h0, 1'b0, 1'b0)); // 7
        tbl.push_back(mk(0, 12'hF11, 1'b0, 1'b1, 32'h1,        G0,  32'h0,        1'b0, 1'b0, 64'h0, 1'b1, 1'b0)); // 8
        tbl.push_back(mk(0, 12'hF11, 1'b1, 1'b0, 32'h0,        G0,  32'h1,        1'b1, 1'b0, 64'h0, 1'b0, 1'b0)); // 9
        tbl.push_back(mk(0, 12'hF02, 1'b1, 1'b1, 32'h7,        G0,  32'h0,        1'b1, 1'b1, O7,    1'b0, 1'b0)); // 10
        tbl.push_back(mk(0, 12'hF02, 1'b1, 1'b1, 32'h9,        G0,  32'h7,        1'b1, 1'b1, O9,    1'b0, 1'b0)); // 11
        tbl.push_back(mk(0, 12'hF02, 1'b0, 1'b0, 32'h0,        G0,  32'h7,        1'b0, 1'b0, 64'h0, 1'b0, 1'b0)); // 12
        tbl.push_back(mk(0, 12'hF02, 1'b1, 1'b0, 32'h0,        G0,  32'h9,        1'b1, 1'b0, 64'h0, 1'b0, 1'b0)); // 13
        tbl.push_back(mk(0, 12'hF00, 1'b1, 1'b0, 32'h0,        G5,  32'h0,        1'b1, 1'b0, 64'h0, 1'b1, 1'b0)); // 14
        tbl.push_back(mk(0, 12'hF00, 1'b1, 1'b0, 32'h0,        G5,  32'h0,        1'b1, 1'b0, 64'h0, 1'b1, 1'b0)); // 15
        tbl.push_back(mk(0, 12'hF00, 1'b1, 1'b0, 32'h0,        G5,  32'h5,        1'b1, 1'b0, 64'h0, 1'b1, 1'b1)); // 16
        tbl.push_back(mk(0, 12'h000, 1'b0, 1'b0, 32'h0,        G35, 32'h5,        1'b0, 1'b0, 64'h0, 1'b1, 1'b1)); // 17
        tbl.push_back(mk(0, 12'h000, 1'b0, 1'b0, 32'h0,        G35, 32'h5,        1'b0, 1'b0, 64'h0, 1'b1, 1'b1)); // 18
        tbl.push_back(mk(0, 12'hF10, 1'b1, 1'b0, 32'h0,        G35, 32'h1,        1'b1, 1'b0, 64'h0, 1'b1, 1'b0)); // 19
        tbl.push_back(mk(0, 12'hF10, 1'b1, 1'b0, 32'h0,        G35, 32'h2,        1'b1, 1'b0, 64'h0, 1'b1, 1'b0)); // 20
        tbl.push_back(mk(0, 12'hF10, 1'b1, 1'b0, 32'h0,        G35, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0, 1'b0)); // 21
        tbl.push_back(mk(0, 12'hF01, 1'b1, 1'b0, 32'h0,        G35, 32'h3,        1'b1, 1'b0, 64'h0, 1'b0, 1'b0)); // 22
        tbl.push_back(mk(0, 12'h000, 1'b0, 1'b0, 32'h0,        G36, 32'h3,        1'b0, 1'b0, 64'h0, 1'b0, 1'b0)); // 23
        tbl.push_back(mk(0, 12'h000, 1'b0, 1'b0, 32'h0,        G36, 32'h3,        1'b0, 1'b0, 64'h0, 1'b1, 1'b0)); // 24
        tbl.push_back(mk(0, 12'hF10, 1'b0, 1'b1, 32'h1,        G36, 32'h3,        1'b0, 1'b0, 64'h0, 1'b1, 1'b1)); // 25
        tbl.push_back(mk(0, 12'hF10, 1'b1, 1'b0, 32'h0,        G36, 32'h1,        1'b1, 1'b0, 64'h0, 1'b1, 1'b0)); // 26
        tbl.push_back(mk(0, 12'h000, 1'b0, 1'b0, 32'h0,        G46, 32'h1,        1'b0, 1'b0, 64'h0, 1'b0, 1'b0)); // 27
        tbl.push_back(mk(0, 12'h000, 1'b0, 1'b0, 32'h0,        G46, 32'h1,        1'b0, 1'b0, 64'h0, 1'b0, 1'b0)); // 28
        tbl.push_back(mk(0, 12'h000, 1'b0, 1'b0, 32'h0,        G46, 32'h1,        1'b0, 1'b0, 64'h0, 1'b1, 1'b0)); // 29
        tbl.push_back(mk(0, 12'hF11, 1'b0, 1'b1, 32'h3,        G46, 32'h1,        1'b0, 1'b0, 64'h0, 1'b1, 1'b1)); // 30
        tbl.push_back(mk(0, 12'hF10, 1'b0, 1'b1, 32'h1,        G46, 32'h1,        1'b0, 1'b0, 64'h0, 1'b1, 1'b1)); // 31
        tbl.push_back(mk(0, 12'hF10, 1'b0, 1'b1, 32'h2,        G46, 32'h1,        1'b0, 1'b0, 64'h0, 1'b1, 1'b0)); // 32
        tbl.push_back(mk(0, 12'hF10, 1'b1, 1'b0, 32'h0,        G46, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0, 1'b0)); // 33
        tbl.push_back(mk(0, 12'hF11, 1'b1, 1'b0, 32'h0,        G46, 32'h3,        1'b1, 1'b1, O9,    1'b0, 1'b0)); // 34

        // Reset state
        rst           = 1'b1;
        bus.csr_addr  = '0;
        bus.csr_re    = 1'b0;
        bus.csr_we    = 1'b0;
        bus.csr_wdata = '0;
        gpio_in       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", {32'd0, bus.csr_rdata}, 64'd0);
        check("reset hit", {63'd0, bus.csr_hit}, 64'd0);
        check("reset irq", {63'd0, change_irq}, 64'd0);
        check("reset gpio_out", gpio_out, 64'd0);
        @(negedge clk);

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k], k);
        end

        // Reset with a coincident write/read: reset wins, the write is lost
        apply(mk(1, 12'hF02, 1'b1, 1'b1, 32'h5, G46, 32'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0), 35);
        apply(mk(0, 12'hF02, 1'b1, 1'b0, 32'h0, G11, 32'h0, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0), 36);

        // Inputs toggling while the synchroniser flushes: mask is 0, irq stays low
        apply(mk(0, 12'hF10, 1'b1, 1'b0, 32'h0, G22, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0), 37);
        apply(mk(0, 12'h000, 1'b0, 1'b0, 32'h0, G0,  32'h0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0), 38);
        apply(mk(0, 12'hF10, 1'b1, 1'b0, 32'h0, G0,  32'h3, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0), 39);
        apply(mk(0, 12'hF11, 1'b1, 1'b0, 32'h0, G0,  32'h0, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0), 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
